// File: rtl/bin2bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   bcd_state_e   : controller FSM states
//   bcd_digit_t   : one packed BCD digit
//   BCD_ADJ_*     : double-dabble add-3 correction constants
//   bcd_adjust()  : pre-shift correction applied to one digit
// -----------------------------------------------------------------------------
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } bcd_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

  // A digit of 5..9 becomes >= 10 after doubling; adding 3 first makes the
  // doubled value carry cleanly into the next digit.
  function automatic bcd_digit_t bcd_adjust(input bcd_digit_t d);
    return (d >= BCD_ADJ_THRESH) ? bcd_digit_t'(d + BCD_ADJ_ADD) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_ctrl_if
// Handshake bundle of the binary-to-BCD converter.
//   in_valid/in_ready/bin_in      : binary word input handshake
//   out_valid/out_ready/bcd_out   : packed BCD result handshake
//   busy                          : conversion in progress
// Modports: master = producer/consumer side, slave = converter side.
// -----------------------------------------------------------------------------
interface bin2bcd_seq_ctrl_if #(
  parameter int BIN_W      = 16,
  parameter int NUM_DIGITS = 5
);

  logic                    in_valid;
  logic                    in_ready;
  logic [BIN_W-1:0]        bin_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic                    busy;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, busy
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, busy
  );

endinterface

// File: rtl/bcd_digit_shift.sv
// -----------------------------------------------------------------------------
// bcd_digit_shift
// One 4-bit double-dabble segment of the BCD digit chain.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear (priority over en)
//   en         : adjust-and-shift this edge
//   cin        : bit shifted in from the previous (less significant) stage
//   digit      : current BCD digit
//   cout       : bit shifted out to the next (more significant) stage
// -----------------------------------------------------------------------------
module bcd_digit_shift
  import bin2bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       cin,
  output bcd_digit_t digit,
  output logic       cout
);

  bcd_digit_t digit_q, digit_d;
  bcd_digit_t adj;

  // cout depends only on this stage's register, so the chain has no ripple path.
  assign adj   = bcd_adjust(digit_q);
  assign cout  = adj[3];
  assign digit = digit_q;

  always_comb begin
    // NOTE: default first so every path assigns digit_d and no latch is inferred.
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (en) begin
      digit_d = {adj[2:0], cin};
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_ctrl
// Sequencer for a double-dabble binary-to-BCD converter. Accepts a binary
// word, clears the digit chain, shifts BIN_W bits MSB-first through it, then
// presents the packed BCD result until the consumer takes it.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : bin2bcd_seq_ctrl_if.slave (input/output handshakes, busy)
//   ovf        : only when BIN2BCD_OVF_EN is defined; result truncated
//                (value >= 10^NUM_DIGITS), valid with out_valid
// Optional feature macro: BIN2BCD_OVF_EN
// -----------------------------------------------------------------------------
module bin2bcd_seq_ctrl
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W      = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bin2bcd_seq_ctrl_if.slave     bus
`ifdef BIN2BCD_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  bcd_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIN_W-1:0]        bin_sr_q, bin_sr_d;
  logic                    accept;
  logic                    shift_en;
  logic [NUM_DIGITS:0]     carry;
  logic [4*NUM_DIGITS-1:0] bcd_flat;

  assign accept   = (state_q == ST_IDLE) && bus.in_valid;
  assign shift_en = (state_q == ST_SHIFT);
  assign carry[0] = bin_sr_q[BIN_W-1];

  // Digit chain: digit 0 (ones) receives the binary MSB, each stage feeds the next.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_shift u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (shift_en),
      .cin   (carry[i]),
      .digit (bcd_flat[4*i +: 4]),
      .cout  (carry[i+1])
    );
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)              state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(1))  state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready)       state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // Datapath: shift register and remaining-bit counter.
  always_comb begin
    cnt_d    = cnt_q;
    bin_sr_d = bin_sr_q;
    if (accept) begin
      cnt_d    = CNT_W'(BIN_W);
      bin_sr_d = bus.bin_in;
    end else if (shift_en) begin
      cnt_d    = cnt_q - CNT_W'(1);
      bin_sr_d = bin_sr_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bin_sr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_sr_q <= bin_sr_d;
    end
  end

`ifdef BIN2BCD_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky: any carry out of the top digit means the result wrapped.
  always_comb begin
    ovf_d = ovf_q;
    if (accept)                          ovf_d = 1'b0;
    else if (shift_en && carry[NUM_DIGITS]) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  // Outputs are decoded from the state register only.
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.busy      = (state_q == ST_SHIFT);
    bus.out_valid = (state_q == ST_DONE);
    bus.bcd_out   = bcd_flat;
  end

endmodule
